// File: rtl/m_sap2_pkg.sv
// Shared types and constants for the SAP-2 memory bus responder.
package m_sap2_pkg;

  localparam int unsigned AddrWDefault = 16;
  localparam int unsigned DataWDefault = 8;

  localparam int unsigned MarRst = 0;
  localparam int unsigned MdrRst = 0;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OpRd,
    OpWr
  } op_e;

endpackage

// File: rtl/m_sync_ram.sv
// Single-port RAM: synchronous write, combinational read.
module m_sync_ram #(
  parameter int unsigned Depth = 4096,
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/m_memory_bus_responder.sv
// SAP-2 memory-side responder: MAR/MDR, RAM and a wait-state access FSM with
// ready/ack handshake toward the controller-sequencer.
module m_memory_bus_responder
  import m_sap2_pkg::*;
#(
  parameter int unsigned ADDR_W      = AddrWDefault,
  parameter int unsigned DATA_W      = DataWDefault,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iBus,
  input  logic              iLm,
  input  logic              iLmdr,
  input  logic              iRd,
  input  logic              iWr,
  input  logic              iEmdr,
  output logic [DATA_W-1:0] oBus,
  output logic              oBusEn,
  output logic              oReady,
  output logic              oAck,
  output logic              oErr,
  output logic [ADDR_W-1:0] oMAR,
  output logic [DATA_W-1:0] oMDR
);

  localparam int unsigned RamAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = 4;
  localparam int unsigned CmpW  = ADDR_W + 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_of_range;
  logic              any_strobe;

  assign out_of_range = {1'b0, mar_q} >= CmpW'(DEPTH);
  assign any_strobe   = iLm | iLmdr | iRd | iWr;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iLm) begin
          mar_d = iAddr;
        end
        if (iLmdr) begin
          mdr_d = iBus;
        end
        if (iRd && iWr) begin
          err_d = 1'b1;
        end else if (iRd || iWr) begin
          op_d    = iWr ? OpWr : OpRd;
          cnt_d   = CntW'(WAIT_STATES);
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Strobes while busy are dropped and flagged.
        err_d = any_strobe;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StDone;
          err_d   = any_strobe | out_of_range;
          if (op_q == OpRd) begin
            mdr_d = out_of_range ? '0 : ram_rdata;
          end else begin
            ram_we = ~out_of_range;
          end
        end
      end
      StDone: begin
        err_d   = any_strobe;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= StIdle;
      op_q    <= OpRd;
      cnt_q   <= '0;
      mar_q   <= ADDR_W'(MarRst);
      mdr_q   <= DATA_W'(MdrRst);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Reset on the commit edge must still cancel the write.
  m_sync_ram #(
    .Depth(DEPTH),
    .DataW(DATA_W),
    .AddrW(RamAw)
  ) u_ram (
    .clk_i  (iClk),
    .we_i   (ram_we & ~iReset),
    .addr_i (mar_q[RamAw-1:0]),
    .wdata_i(mdr_q),
    .rdata_o(ram_rdata)
  );

  assign oReady = (state_q == StIdle);
  assign oAck   = (state_q == StDone);
  assign oErr   = err_q;
  assign oBus   = mdr_q;
  assign oBusEn = iEmdr & oReady;
  assign oMAR   = mar_q;
  assign oMDR   = mdr_q;

endmodule

// File: tb/tb_m_memory_bus_responder.sv
// Directed bench: instance 0 uses two wait states, instance 1 uses none.
module tb_m_memory_bus_responder;

  logic        clk;
  logic        rst;
  logic [15:0] addr  [2];
  logic [7:0]  bus   [2];
  logic        lm    [2];
  logic        lmdr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic        emdr  [2];
  logic [7:0]  obus  [2];
  logic        busen [2];
  logic        ready [2];
  logic        ack   [2];
  logic        err   [2];
  logic [15:0] mar   [2];
  logic [7:0]  mdr   [2];

  typedef struct {
    int         busy;
    logic [7:0] mdr;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  m_memory_bus_responder #(
    .ADDR_W(16), .DATA_W(8), .DEPTH(4096), .WAIT_STATES(2)
  ) u_dut (
    .iClk(clk), .iReset(rst), .iAddr(addr[0]), .iBus(bus[0]), .iLm(lm[0]),
    .iLmdr(lmdr[0]), .iRd(rd[0]), .iWr(wr[0]), .iEmdr(emdr[0]), .oBus(obus[0]),
    .oBusEn(busen[0]), .oReady(ready[0]), .oAck(ack[0]), .oErr(err[0]),
    .oMAR(mar[0]), .oMDR(mdr[0])
  );

  m_memory_bus_responder #(
    .ADDR_W(16), .DATA_W(8), .DEPTH(4096), .WAIT_STATES(0)
  ) u_dut_zw (
    .iClk(clk), .iReset(rst), .iAddr(addr[1]), .iBus(bus[1]), .iLm(lm[1]),
    .iLmdr(lmdr[1]), .iRd(rd[1]), .iWr(wr[1]), .iEmdr(emdr[1]), .oBus(obus[1]),
    .oBusEn(busen[1]), .oReady(ready[1]), .oAck(ack[1]), .oErr(err[1]),
    .oMAR(mar[1]), .oMDR(mdr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, push its expectation, then follow the busy window.
  task automatic run_cmd(input int d, input string tag, input logic [15:0] a,
                         input logic do_lm, input logic do_lmdr, input logic [7:0] b,
                         input logic r, input logic w, input int exp_busy,
                         input logic [7:0] exp_mdr, input logic exp_err);
    exp_t       e;
    int         n;
    int         ack_at;
    logic [7:0] got_mdr;
    logic       got_err;
    e.busy = exp_busy;
    e.mdr  = exp_mdr;
    e.err  = exp_err;
    sb.push_back(e);
    addr[d] = a;
    bus[d]  = b;
    lm[d]   = do_lm;
    lmdr[d] = do_lmdr;
    rd[d]   = r;
    wr[d]   = w;
    tick();
    lm[d]   = 1'b0;
    lmdr[d] = 1'b0;
    rd[d]   = 1'b0;
    wr[d]   = 1'b0;
    n       = 0;
    ack_at  = -1;
    got_mdr = 'x;
    got_err = 'x;
    for (int i = 0; i < 40 && !ready[d]; i++) begin
      n++;
      if (ack[d]) begin
        ack_at  = n;
        got_mdr = mdr[d];
        got_err = err[d];
      end
      tick();
    end
    e = sb.pop_front();
    check({tag, ".busy"}, n, e.busy);
    check({tag, ".ack_cycle"}, ack_at, e.busy);
    check({tag, ".mdr"}, got_mdr, e.mdr);
    check({tag, ".err"}, got_err, e.err);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0;
      bus[d]  = '0;
      lm[d]   = 1'b0;
      lmdr[d] = 1'b0;
      rd[d]   = 1'b0;
      wr[d]   = 1'b0;
      emdr[d] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.ready", ready[0], 1'b1);
    check("rst.ack", ack[0], 1'b0);
    check("rst.err", err[0], 1'b0);
    check("rst.busen", busen[0], 1'b0);
    check("rst.mar", mar[0], 16'h0000);
    check("rst.mdr", mdr[0], 8'h00);

    // Zero wait states
    run_cmd(1, "zw_wr", 16'h0100, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 2, 8'h3C, 1'b0);
    run_cmd(1, "zw_rd", 16'h0100, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2, 8'h3C, 1'b0);

    // Write then read with two wait states
    run_cmd(0, "wr10", 16'h0010, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 4, 8'hA5, 1'b0);
    run_cmd(0, "rd10", 16'h0010, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4, 8'hA5, 1'b0);
    emdr[0] = 1'b1;
    #1;
    check("emdr.busen", busen[0], 1'b1);
    check("emdr.bus", obus[0], 8'hA5);
    emdr[0] = 1'b0;
    tick();

    // Out of range: 0x2000 aliases 0x0000 in the array if not suppressed
    run_cmd(0, "wr0", 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 4, 8'h5A, 1'b0);
    run_cmd(0, "wr_oor", 16'h2000, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 4, 8'hFF, 1'b1);
    run_cmd(0, "rd0", 16'h0000, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 4, 8'h5A, 1'b0);
    run_cmd(0, "rd_oor", 16'h2000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4, 8'h00, 1'b1);

    // Read and write together
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    wr[0] = 1'b0;
    check("rdwr.err", err[0], 1'b1);
    check("rdwr.ack", ack[0], 1'b0);
    check("rdwr.ready", ready[0], 1'b1);
    tick();
    check("rdwr.err_clear", err[0], 1'b0);

    // MAR load while busy
    addr[0] = 16'h0010;
    lm[0]   = 1'b1;
    rd[0]   = 1'b1;
    tick();
    rd[0]   = 1'b0;
    addr[0] = 16'h0444;
    emdr[0] = 1'b1;
    #1;
    check("busy.busen", busen[0], 1'b0);
    tick();
    lm[0]   = 1'b0;
    emdr[0] = 1'b0;
    check("busy.err", err[0], 1'b1);
    check("busy.mar", mar[0], 16'h0010);
    n = 0;
    while (!ready[0] && n < 20) begin
      n++;
      tick();
    end
    check("busy.ready", ready[0], 1'b1);
    check("busy.mdr", mdr[0], 8'hA5);

    // Reset during the second ACCESS cycle of a write
    run_cmd(0, "wr20", 16'h0020, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 4, 8'h11, 1'b0);
    addr[0] = 16'h0020;
    bus[0]  = 8'h77;
    lm[0]   = 1'b1;
    lmdr[0] = 1'b1;
    wr[0]   = 1'b1;
    tick();
    lm[0]   = 1'b0;
    lmdr[0] = 1'b0;
    wr[0]   = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.mar", mar[0], 16'h0000);
    check("mrst.mdr", mdr[0], 8'h00);
    check("mrst.ready", ready[0], 1'b1);
    check("mrst.ack", ack[0], 1'b0);
    tick();
    check("mrst.ack_later", ack[0], 1'b0);
    run_cmd(0, "rd20", 16'h0020, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4, 8'h11, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
